shift_unit: RTL and testbench
=============================

# shift_unit

8-bit multi-mode shift register that produces the byte shown on the two-digit hex display. Each rising edge of the step input applies one operation selected by `op`: clear, load, one of five shift/rotate modes, or one LFSR step. The registered byte `q` drives the display decoder's 8-bit code input directly. An optional auto-run prescaler steps the register periodically without button presses.

## Interface
- `WIDTH`, 8: register width. Only 8 is supported; the LFSR taps are defined for 8 bits.
- `PRESCALE`, 10_000_000: auto-run tick period, in clk cycles. Minimum 2.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `op`  in  3  operation select, sampled on the step cycle.
- `din`  in  8  parallel load data, used by op 001.
- `sin`  in  1  serial input bit, used by op 101.
- `step`  in  1  step request, level; already synchronized to clk.
- `auto`  in  1  auto-run enable; ignored unless the macro is defined.
- `q`  out  8  register contents, to the display decoder.
- `upd`  out  1  one-cycle pulse marking that `q` was just written.

## Operation
- Edge detect: `step_d` is a registered copy of `step`.
  - `fire = step & ~step_d`.
  - One press gives exactly one operation, however long `step` is held.
- Trigger: `go = fire | tick`. A simultaneous `fire` and `tick` apply the operation once.
- Operations on `go`, using the current `q`:
  - 000: clear; q ← 8'h00.
  - 001: load; q ← din.
  - 010: logical right; q ← {1'b0, q[7:1]}.
  - 011: logical left; q ← {q[6:0], 1'b0}.
  - 100: arithmetic right; q ← {q[7], q[7:1]}.
  - 101: serial-in right; q ← {sin, q[7:1]}.
  - 110: rotate right; q ← {q[0], q[7:1]}.
  - 111: LFSR step for polynomial x^8+x^4+x^3+x^2+1.
    - fb = q[4]^q[3]^q[2]^q[0]; q ← {fb, q[7:1]}.
    - If q == 8'h00, q ← 8'h01 instead (lockup escape).
- With no `go`, q holds its value.
- All ops are well defined; there is no illegal encoding.

## Timing
- Reset values: q = 8'h00, upd = 0, prescaler = 0, tick = 0.
- During reset `step_d` loads `step`. A button held through reset release therefore does not fire.
- `q` updates at the first clk edge where step = 1 and step_d = 0. Latency is one edge from the step rising to the new `q`.
- `upd` is registered. It is high for the single cycle in which the new `q` is first visible.
- Back-to-back operations need `step` low for at least one sampled cycle between presses.
- `rst` asserted in any cycle overrides `go`.
  - q = 0 on the following cycle.
  - Any pending tick is discarded.

## Configuration
- Macro: `SHIFT_UNIT_AUTORUN_EN`.
- Defined:
  - Prescaler counts 0..PRESCALE-1 while `auto` = 1.
  - `tick` is a registered pulse, high for one cycle when the count wraps, giving one operation every PRESCALE cycles.
  - `auto` = 0 clears the count to 0 synchronously and holds `tick` low.
  - First tick arrives PRESCALE cycles after `auto` rises.
- Undefined:
  - No counter logic exists and `tick` is constant 0.
  - `auto` is an unused input.
  - Behaviour is identical to the defined case with auto = 0.

## Structure
- Package `shift_pkg`:
  - Localparams for the eight op encodings (OP_CLR … OP_LFSR).
  - LFSR tap mask 8'b0001_1101, for taps 4, 3, 2, 0.
  - The lockup seed 8'h01.
- Sub-module `edge_detect` (`clk`, `rst`, `in`, `rise`): holds `step_d`, including the load-on-reset behaviour.
- The next-state mux and the prescaler stay inside `shift_unit`.

## Test plan
- Reset with step = 1 held, then release → q = 8'h00, upd = 0, and no operation while step stays high.
- op = 001, din = 8'h96, one press → q = 8'h96 with one upd pulse. Then op = 100, press → q = 8'hCB. Hold step high 20 cycles → q unchanged.
- Load 8'h81. op = 011, press → 8'h02. op = 110 from 8'h01, press → 8'h80. op = 101, sin = 1 from 8'h00, press → 8'h80.
- op = 111 from 8'h00:
  - Presses give 8'h01 → 8'h80 → 8'h40.
  - From 8'h01, 255 presses return to 8'h01 with no 8'h00 in between (maximal length).
- With macro, PRESCALE = 4, auto = 1, op = 010, q = 8'hF0:
  - Shifts occur every 4 cycles: 78, 3C, 1E.
  - A press coinciding with a tick gives a single shift.
  - Dropping auto stops the shifts.
- rst asserted mid auto-run → q = 8'h00 the next cycle and the prescaler restarts from 0.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op encodings and LFSR constants for shift_unit
package shift_pkg;
    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_SIN  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_LFSR = 3'b111;

    // taps 4, 3, 2, 0 of x^8+x^4+x^3+x^2+1
    localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        if (q == 8'h00) return LFSR_SEED;
        return {^(q & LFSR_TAPS), q[7:1]};
    endfunction
endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector for the synchronized step level
module edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_rise
);
    logic r_d;

    // loading the live level during reset keeps a held button from firing at release
    always_ff @(posedge i_clk) begin
        if (i_rst) r_d <= i_in;
        else       r_d <= i_in;
    end

    assign o_rise = i_in & ~r_d;
endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - 8-bit multi-mode shift register for the hex display
// Optional auto-run prescaler enabled by `define SHIFT_UNIT_AUTORUN_EN
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 10_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_sin,
    input  logic             i_step,
    input  logic             i_auto,
    output logic [WIDTH-1:0] o_q,
    output logic             o_upd
);
    logic [WIDTH-1:0] r_q;
    logic             r_upd;
    logic             w_fire;
    logic             w_tick;
    logic             w_go;
    logic [WIDTH-1:0] w_q_next;

    edge_detect u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_step),
        .o_rise (w_fire)
    );

`ifdef SHIFT_UNIT_AUTORUN_EN
    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_auto) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign w_tick = r_tick;
`else
    logic w_unused_auto;
    assign w_unused_auto = i_auto;
    assign w_tick        = 1'b0;
`endif

    assign w_go = w_fire | w_tick;

    always_comb begin
        w_q_next = r_q;
        case (i_op)
            OP_CLR:  w_q_next = '0;
            OP_LOAD: w_q_next = i_din;
            OP_SRL:  w_q_next = {1'b0, r_q[WIDTH-1:1]};
            OP_SLL:  w_q_next = {r_q[WIDTH-2:0], 1'b0};
            OP_SRA:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            OP_SIN:  w_q_next = {i_sin, r_q[WIDTH-1:1]};
            OP_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
            default: w_q_next = lfsr_next(r_q);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= '0;
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_go;
            if (w_go) r_q <= w_q_next;
        end
    end

    assign o_q   = r_q;
    assign o_upd = r_upd;
endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - randomized self-checking bench for shift_unit
`timescale 1ns/1ps
module tb_shift_unit;
`ifdef SHIFT_UNIT_AUTORUN_EN
    localparam int P = 4;
`else
    localparam int P = 10_000_000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op = 3'd0;
    logic [7:0] din = 8'd0;
    logic       sin = 1'b0;
    logic       step = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] q;
    logic       upd;

    int checks = 0;
    int errors = 0;

    shift_unit #(.WIDTH(8), .PRESCALE(P)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_op  (op),
        .i_din (din),
        .i_sin (sin),
        .i_step(step),
        .i_auto(auto_en),
        .o_q   (q),
        .o_upd (upd)
    );

    always #5 clk = ~clk;

    // reference model: operation table straight from the op definitions
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] v,
                                          input logic [7:0] d, input logic s);
        logic fb;
        case (o)
            3'd0: return 8'h00;
            3'd1: return d;
            3'd2: return v / 2;
            3'd3: return v * 2;
            3'd4: return (v / 2) | (v & 8'h80);
            3'd5: return (v / 2) | (s ? 8'h80 : 8'h00);
            3'd6: return (v / 2) | ((v % 2) ? 8'h80 : 8'h00);
            default: begin
                if (v == 8'h00) return 8'h01;
                fb = v[4] ^ v[3] ^ v[2] ^ v[0];
                return (v / 2) | (fb ? 8'h80 : 8'h00);
            end
        endcase
    endfunction

    logic [7:0] m_q = 8'h00;
    logic       m_upd = 1'b0;
    logic       m_prev = 1'b0;
    int         m_run = 0;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        logic go;
        go = (step && !m_prev) || (m_run > 0 && (m_run % P) == 0);
        if (rst) begin
            m_q = 8'h00;
            m_upd = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_upd = go;
            if (go) m_q = ref_op(op, m_q, din, sin);
        end
        if (rst || !auto_en) m_run = 0;
        else                 m_run = m_run + 1;
        m_prev = step;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (q !== m_q || upd !== m_upd) begin
                errors++;
                $display("FAIL model q=%h upd=%b required q=%h upd=%b at %0t", q, upd, m_q, m_upd, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] o, input logic [7:0] d, input logic s);
        @(negedge clk);
        op = o; din = d; sin = s; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] start;
        bit saw_zero;
        // reset with step held high, then release with step still high
        step = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_q", q, 8'h00);
        chk("reset_upd", {7'd0, upd}, 8'h00);
        step = 1'b0;
        @(negedge clk);

        press(3'd1, 8'h96, 1'b0);
        chk("load_96", q, 8'h96);
        @(negedge clk);
        op = 3'd4; step = 1'b1;
        @(negedge clk);
        chk("sra_cb", q, 8'hCB);
        chk("upd_pulse", {7'd0, upd}, 8'h01);
        repeat (20) @(negedge clk);
        chk("hold_cb", q, 8'hCB);
        step = 1'b0;
        @(negedge clk);

        press(3'd1, 8'h81, 1'b0);
        press(3'd3, 8'h00, 1'b0);
        chk("sll_02", q, 8'h02);
        press(3'd1, 8'h01, 1'b0);
        press(3'd6, 8'h00, 1'b0);
        chk("ror_80", q, 8'h80);
        press(3'd0, 8'h00, 1'b0);
        press(3'd5, 8'h00, 1'b1);
        chk("sin_80", q, 8'h80);

        press(3'd0, 8'h00, 1'b0);
        press(3'd7, 8'h00, 1'b0);
        chk("lfsr_01", q, 8'h01);
        press(3'd7, 8'h00, 1'b0);
        chk("lfsr_80", q, 8'h80);
        press(3'd7, 8'h00, 1'b0);
        chk("lfsr_40", q, 8'h40);

        press(3'd1, 8'h01, 1'b0);
        saw_zero = 1'b0;
        for (int i = 0; i < 255; i++) begin
            press(3'd7, 8'h00, 1'b0);
            if (q == 8'h00 || (i < 254 && q == 8'h01)) saw_zero = 1'b1;
        end
        chk("lfsr_period", q, 8'h01);
        chk("lfsr_no_early_repeat", {7'd0, saw_zero}, 8'h00);

`ifdef SHIFT_UNIT_AUTORUN_EN
        press(3'd1, 8'hF0, 1'b0);
        op = 3'd2;
        auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int budget;
            budget = 0;
            start = q;
            @(negedge clk);
            while (!upd && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            case (k)
                0: chk("auto_78", q, 8'h78);
                1: chk("auto_3c", q, 8'h3C);
                default: chk("auto_1e", q, 8'h1E);
            endcase
        end
        // press landing on the same edge as a tick
        repeat (3) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        chk("coincide_0f", q, 8'h0F);
        step = 1'b0;
        @(negedge clk);
        auto_en = 1'b0;
        @(negedge clk);
        start = q;
        repeat (12) @(negedge clk);
        chk("auto_off_hold", q, start);
        auto_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_auto", q, 8'h00);
        auto_en = 1'b0;
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(63) == 0);
            step = ($urandom_range(2) == 0);
            op   = 3'($urandom_range(7));
            din  = 8'($urandom_range(255));
            sin  = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) auto_en = ~auto_en;
        end
        rst = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
